// File: rtl/cjb_mul8_seq_ctrl.sv
// rtl/cjb_mul8_seq_ctrl.sv - 8x8 unsigned shift-add multiplier controller with start/done handshake
// One shared 8-bit ripple adder is reused over 8 CALC cycles; the product is committed on entry to DONE.

module cjb_8bit_addsub_struc_v (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  input  logic       sub,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf
);

  logic [7:0] yx;
  logic [8:0] c;

  assign yx   = y ^ {8{sub}};
  assign c[0] = cin ^ sub;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_fa
      assign sum[i]   = x[i] ^ yx[i] ^ c[i];
      assign c[i + 1] = (x[i] & yx[i]) | (c[i] & (x[i] ^ yx[i]));
    end
  endgenerate

  assign cout = c[8];
  assign ovf  = c[8] ^ c[7];

endmodule

module cjb_mul8_seq_ctrl #(
  parameter bit CLR_ON_START = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        hi_nz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  m_r, a_r, q_r;
  logic [2:0]  cnt;
  logic [7:0]  m_nxt, a_nxt, q_nxt;
  logic [2:0]  cnt_nxt;
  logic        busy_nxt, done_nxt, hi_nz_nxt;
  logic [15:0] result_nxt;

  logic [7:0]  add_sum;
  logic        add_cout;
  logic        ovf_unused;
  logic [8:0]  ca;
  logic [7:0]  a_shift, q_shift;

  cjb_8bit_addsub_struc_v u_adder (
    .x    (a_r),
    .y    (m_r),
    .cin  (1'b0),
    .sub  (1'b0),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (ovf_unused)
  );

  // {C,A} after the conditional add, then the whole {C,A,Q} shifts right by one
  assign ca      = q_r[0] ? {add_cout, add_sum} : {1'b0, a_r};
  assign a_shift = ca[8:1];
  assign q_shift = {ca[0], q_r[7:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    m_nxt      = m_r;
    a_nxt      = a_r;
    q_nxt      = q_r;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    result_nxt = result;
    hi_nz_nxt  = hi_nz;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          m_nxt     = a;
          q_nxt     = b;
          a_nxt     = 8'd0;
          cnt_nxt   = 3'd0;
          busy_nxt  = 1'b1;
          state_nxt = CALC;
          if (CLR_ON_START) begin
            result_nxt = 16'd0;
            hi_nz_nxt  = 1'b0;
          end
        end
      end
      CALC: begin
        if (abort) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          a_nxt   = a_shift;
          q_nxt   = q_shift;
          cnt_nxt = cnt + 3'd1;
          // Final iteration: commit the product so it is valid while done is high
          if (cnt == 3'd7) begin
            state_nxt  = DONE;
            done_nxt   = 1'b1;
            result_nxt = {a_shift, q_shift};
            hi_nz_nxt  = |a_shift;
          end
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_r    <= 8'd0;
      a_r    <= 8'd0;
      q_r    <= 8'd0;
      cnt    <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 16'd0;
      hi_nz  <= 1'b0;
    end else begin
      m_r    <= m_nxt;
      a_r    <= a_nxt;
      q_r    <= q_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
      hi_nz  <= hi_nz_nxt;
    end
  end

endmodule
